ssd_mux_driver: RTL and testbench



---
 rtl/ssd_mux_driver.sv | 157 +++++++++++++++
 tb/tb_ssd_mux_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed, double-buffered hex driver for NUM_SSD PmodSSD modules.
// Optional macro SSD_LEADING_ZERO_BLANK_EN: an MSB digit whose nibble is 0 stays dark.
module ssd_mux_driver #(
    parameter int unsigned NUM_SSD     = 2,
    parameter int unsigned SHOW_CYCLES = 50000,
    parameter int unsigned DEAD_CYCLES = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_SSD-1:0]   value,
    input  logic [2*NUM_SSD-1:0]   blank,
    input  logic                   load,
    output logic                   update_pending,
    output logic                   frame_tick,
    output logic [8*NUM_SSD-1:0]   pmod_port1,
    output logic [8*NUM_SSD-1:0]   pmod_port2
);

    localparam int unsigned MAXC      = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
    localparam int unsigned CW        = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        SHOW_LSB,
        BLANK_TO_MSB,
        SHOW_MSB,
        BLANK_TO_LSB
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_last;
    logic                   w_boundary;
    logic                   w_sel;
    logic                   w_lit;

    logic [8*NUM_SSD-1:0]   r_pend_val;
    logic [2*NUM_SSD-1:0]   r_pend_blank;
    logic [8*NUM_SSD-1:0]   r_shad_val;
    logic [2*NUM_SSD-1:0]   r_shad_blank;
    logic [8*NUM_SSD-1:0]   w_p1;
    logic [8*NUM_SSD-1:0]   w_p2;
    logic [3:0]             w_nib;
    logic                   w_dark;
    logic [6:0]             w_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'h3F;  4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;  4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;  4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;  4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;  4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;  4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;  4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;  default: f_decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SHOW_LSB;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt + 1'b1;
        if (r_state == SHOW_LSB || r_state == SHOW_MSB)
            w_last = (r_cnt == CW'(SHOW_CYCLES - 1));
        else
            w_last = (r_cnt == CW'(DEAD_LAST));
        if (w_last) begin
            w_cnt_next = '0;
            case (r_state)
                SHOW_LSB:     w_next = (DEAD_CYCLES > 0) ? BLANK_TO_MSB : SHOW_MSB;
                BLANK_TO_MSB: w_next = SHOW_MSB;
                SHOW_MSB:     w_next = (DEAD_CYCLES > 0) ? BLANK_TO_LSB : SHOW_LSB;
                default:      w_next = SHOW_LSB;
            endcase
        end
    end

    always_comb begin
        w_sel      = (r_state == SHOW_MSB) || (r_state == BLANK_TO_MSB);
        w_lit      = (r_state == SHOW_MSB) || (r_state == SHOW_LSB);
        w_boundary = w_last && (w_next == SHOW_LSB);
    end

    // Pending always follows the latest load so later frames keep showing it,
    // even when a boundary-cycle load bypasses straight into shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_val     <= '0;
            r_pend_blank   <= '1;
            r_shad_val     <= '0;
            r_shad_blank   <= '1;
            update_pending <= 1'b0;
            frame_tick     <= 1'b0;
        end else begin
            frame_tick <= w_boundary;
            if (load) begin
                r_pend_val   <= value;
                r_pend_blank <= blank;
            end
            if (w_boundary) begin
                update_pending <= 1'b0;
                if (load) begin
                    r_shad_val   <= value;
                    r_shad_blank <= blank;
                end else begin
                    r_shad_val   <= r_pend_val;
                    r_shad_blank <= r_pend_blank;
                end
            end else if (load) begin
                update_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_p1   = '0;
        w_p2   = '0;
        w_nib  = '0;
        w_dark = 1'b1;
        w_seg  = '0;
        for (int unsigned k = 0; k < NUM_SSD; k++) begin
            w_nib  = w_sel ? r_shad_val[8*k+4 +: 4] : r_shad_val[8*k +: 4];
            w_dark = w_sel ? r_shad_blank[2*k+1] : r_shad_blank[2*k];
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (w_sel && w_nib == 4'h0)
                w_dark = 1'b1;
`endif
            w_seg = (w_lit && !w_dark) ? f_decode(w_nib) : 7'h00;
            w_p1[8*k+4 +: 4] = w_seg[3:0];
            w_p2[8*k+4 +: 3] = w_seg[6:4];
            w_p2[8*k+7]      = w_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pmod_port1 <= '0;
            pmod_port2 <= '0;
        end else begin
            pmod_port1 <= w_p1;
            pmod_port2 <= w_p2;
        end
    end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Bench for ssd_mux_driver: phase-arithmetic reference model plus vector table and corner sequences.
module tb_ssd_mux_driver;

    localparam int N = 2;
    localparam int S = 4;
    localparam int D = 2;
    localparam int P = 2 * (S + D);
    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank = '0;
    logic        update_pending;
    logic        frame_tick;
    logic [15:0] pmod_port1;
    logic [15:0] pmod_port2;

    always #5 clk = ~clk;

    ssd_mux_driver #(.NUM_SSD(N), .SHOW_CYCLES(S), .DEAD_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .value(value), .blank(blank), .load(load),
        .update_pending(update_pending), .frame_tick(frame_tick),
        .pmod_port1(pmod_port1), .pmod_port2(pmod_port2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a free-running phase within the frame plus pending/shadow copies.
    int          m_phase = 0;
    bit          m_valid = 0;
    logic [15:0] m_pv, m_sv, m_p1, m_p2;
    logic [3:0]  m_pb, m_sb;
    logic        m_upd, m_tick, m_sel, m_lit, m_bnd;
    logic [3:0]  m_nib;
    logic [6:0]  m_sg;

    function automatic logic [6:0] seg_of(input logic [3:0] n, input logic dark, input logic msb);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (msb && n == 4'h0) return 7'h00;
`endif
        if (dark) return 7'h00;
        return SEG[n];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_phase = 0;
            m_pv = '0; m_sv = '0; m_pb = '1; m_sb = '1;
            m_upd = 0; m_tick = 0; m_p1 = '0; m_p2 = '0;
        end else if (m_valid) begin
            m_sel = (m_phase >= S) && (m_phase < 2 * S + D);
            m_lit = (m_phase < S) || ((m_phase >= S + D) && (m_phase < 2 * S + D));
            m_p1 = '0; m_p2 = '0;
            for (int k = 0; k < N; k++) begin
                m_nib = (m_pv === m_pv) ? m_sv[8*k + (m_sel ? 4 : 0) +: 4] : 4'h0;
                m_sg  = m_lit ? seg_of(m_nib, m_sb[2*k + (m_sel ? 1 : 0)], m_sel) : 7'h00;
                m_p1[8*k +: 8] = {m_sg[3:0], 4'h0};
                m_p2[8*k +: 8] = {m_sel, m_sg[6:4], 4'h0};
            end
            m_bnd  = (m_phase == P - 1);
            m_tick = m_bnd;
            if (m_bnd) begin
                m_upd = 0;
                if (load) begin m_sv = value; m_sb = blank; end
                else begin m_sv = m_pv; m_sb = m_pb; end
            end else if (load) begin
                m_upd = 1;
            end
            if (load) begin m_pv = value; m_pb = blank; end
            m_phase = (m_phase + 1) % P;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_port1", pmod_port1, m_p1);
            check("model_port2", pmod_port2, m_p2);
            check("model_pending", update_pending, m_upd);
            check("model_tick", frame_tick, m_tick);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b);
        value = v; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 30);
        check("frame_tick_seen", frame_tick, 1'b1);
    endtask

    // Called on the negedge where rst is first low; expects a dark display, tick at cycle 12.
    task automatic dark_frame(input string tag);
        int hi = 0;
        int tpos = 0;
        logic [15:0] segs = '0;
        for (int i = 1; i <= P + 1; i++) begin
            @(negedge clk);
            if (i <= P) hi += int'(pmod_port2[7]);
            segs |= (pmod_port1 | pmod_port2) & 16'h7F7F;
            if (frame_tick && tpos == 0) tpos = i;
        end
        check({tag, "_dark_segs"}, segs, 16'h0);
        check({tag, "_sel_high"}, hi, 6);
        check({tag, "_tick_pos"}, tpos, P);
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  b;
        logic [15:0] l1, l2, h1, h2;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{16'h12A5, 4'b0000, 16'hB0D0, 16'h5060, 16'h6070, 16'h80F0};
        vecs[1] = '{16'h9E3C, 4'b0000, 16'h9090, 16'h7030, 16'hF0F0, 16'hE0C0};
        vecs[2] = '{16'h7B48, 4'b1001, 16'hC000, 16'h7000, 16'h0060, 16'h80E0};
`ifdef SSD_LEADING_ZERO_BLANK_EN
        vecs[3] = '{16'h06D0, 4'b0000, 16'hD0F0, 16'h7030, 16'h00E0, 16'h80D0};
`else
        vecs[3] = '{16'h06D0, 4'b0000, 16'hD0F0, 16'h7030, 16'hF0E0, 16'hB0D0};
`endif

        rst = 1'b1;
        cyc(3);
        check("rst_port1", pmod_port1, 16'h0);
        check("rst_port2", pmod_port2, 16'h0);
        check("rst_pending", update_pending, 1'b0);
        check("rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        dark_frame("init");
        wait_tick();

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            do_load(vecs[i].v, vecs[i].b);
            check("vec_pending_set", update_pending, 1'b1);
            wait_tick();
            check("vec_pending_clr", update_pending, 1'b0);
            @(negedge clk);
            check("vec_lsb_p1", pmod_port1, vecs[i].l1);
            check("vec_lsb_p2", pmod_port2, vecs[i].l2);
            cyc(4);
            check("dead_to_msb", {pmod_port2[15], pmod_port2[7], (pmod_port1 | pmod_port2) & 16'h7F7F}, {2'b11, 16'h0});
            cyc(2);
            check("vec_msb_p1", pmod_port1, vecs[i].h1);
            check("vec_msb_p2", pmod_port2, vecs[i].h2);
            cyc(4);
            check("dead_to_lsb", {pmod_port2[15], pmod_port2[7], (pmod_port1 | pmod_port2) & 16'h7F7F}, {2'b00, 16'h0});
        end

        // Two loads in one frame: last one wins.
        @(negedge clk);
        do_load(16'h1111, 4'h0);
        check("dbl_pending_1", update_pending, 1'b1);
        @(negedge clk);
        do_load(16'h2222, 4'h0);
        check("dbl_pending_2", update_pending, 1'b1);
        wait_tick();
        check("dbl_pending_clr", update_pending, 1'b0);
        @(negedge clk);
        check("dbl_lsb_p1", pmod_port1, 16'hB0B0);
        check("dbl_lsb_p2", pmod_port2, 16'h5050);
        cyc(6);
        check("dbl_msb_p1", pmod_port1, 16'hB0B0);
        check("dbl_msb_p2", pmod_port2, 16'hD0D0);

        // Load on the boundary cycle goes straight to shadow.
        cyc(4);
        value = 16'h00F0; blank = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("bnd_tick", frame_tick, 1'b1);
        check("bnd_pending", update_pending, 1'b0);
        @(negedge clk);
        check("bnd_lsb0_p1", pmod_port1[7:0], 8'hF0);
        check("bnd_lsb0_p2", pmod_port2[7:0], 8'h30);
        check("bnd_pending2", update_pending, 1'b0);
        cyc(6);
        check("bnd_msb0_p1", pmod_port1[7:0], 8'h10);
        check("bnd_msb0_p2", pmod_port2[7:0], 8'hF0);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        check("bnd_msb1", {pmod_port1[15:8], pmod_port2[15:8]}, 16'h0080);
`else
        check("bnd_msb1", {pmod_port1[15:8], pmod_port2[15:8]}, 16'hF0B0);
`endif

        // Reset mid SHOW_MSB with a load pending.
        do_load(16'h3333, 4'h0);
        check("mid_pending", update_pending, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_p1", pmod_port1, 16'h0);
        check("mid_rst_p2", pmod_port2, 16'h0);
        check("mid_rst_pending", update_pending, 1'b0);
        rst = 1'b0;
        dark_frame("midrst");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            value = 16'($urandom);
            blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            load  = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        load = 1'b0;
        cyc(2 * P);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
